adder_result_checker: RTL and testbench
=======================================

# adder_result_checker

Self-checking monitor for the registered benchmark adder. Watches the same `a`/`b` operands driven into the adder and the adder's `sum` output. Recomputes the expected sum through a delay line matched to the adder's two-register latency and compares it against the observed result. Reports per-cycle mismatches, a saturating error count, a sticky fail flag and the first failing expected value. Used in simulation benches and in on-FPGA wrappers around the generated adder circuits.

## Interface
Parameters:
- `ADDER_WIDTH`, 109, operand width; `sum` is `ADDER_WIDTH+1` bits.
- `LATENCY`, 2, number of clock edges from operands on `a`/`b` to the matching `sum`; must be ≥ 1.
- `ERR_CNT_WIDTH`, 16, width of the error counter.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  checking enable; sampled every edge.
- `a`  in  `ADDER_WIDTH`  operand A, same net that drives the adder.
- `b`  in  `ADDER_WIDTH`  operand B, same net that drives the adder.
- `sum`  in  `ADDER_WIDTH+1`  adder result under test.
- `mismatch`  out  1  registered one-cycle pulse per failed compare.
- `fail`  out  1  sticky; set on the first mismatch.
- `err_count`  out  `ERR_CNT_WIDTH`  mismatches seen; saturates at all-ones.
- `first_err_exp`  out  `ADDER_WIDTH+1`  expected value at the first mismatch.
- `checking`  out  1  high while in CHECK state.

## Operation
- Expected path: `exp0 <= {1'b0,a} + {1'b0,b}`, full `ADDER_WIDTH+1`-bit unsigned sum with no truncation. This value then shifts through `LATENCY` stages in total, so `exp[LATENCY-1]` always holds the sum of the operands sampled `LATENCY` edges earlier.
- The delay line shifts every edge whenever `rst_n`=1, regardless of `en` or state.
- FSM states:
  - IDLE: entered on reset, and on any edge where `en`=0.
  - FILL: entered from IDLE when `en`=1. A counter loads `LATENCY-1` and decrements each edge. When the counter reaches 0 and `en`=1, the FSM moves to CHECK.
  - CHECK: stays while `en`=1.
- If `en` drops in FILL or CHECK, the FSM returns to IDLE immediately. Any pending compare is discarded. Re-enabling always restarts FILL.
- Compare occurs only on edges where the state is CHECK. The check is `sum != exp[LATENCY-1]`.
- On a mismatch:
  - `mismatch` is set to 1 for the next cycle.
  - `err_count` increments unless it is all-ones.
  - If `fail` was 0: `fail` is set to 1 and `first_err_exp` captures `exp[LATENCY-1]`.
- `fail`, `err_count` and `first_err_exp` clear only on reset. Toggling `en` does not clear them.
- Reset values: `mismatch`=0, `fail`=0, `err_count`=0, `first_err_exp`=0, `checking`=0, state IDLE, delay line all zero.

## Timing
- Operands presented in cycle n are compared against `sum` presented in cycle n+`LATENCY`. The corresponding `mismatch` is visible in cycle n+`LATENCY`+1.
- `en` rising at edge k: the first compare happens at edge k+`LATENCY`. No false mismatches occur during pipeline fill.
- Reset mid-CHECK: all outputs take their reset values at that edge. No compare occurs while `rst_n`=0.
- Simultaneous mismatch and `err_count` saturation: the count holds at all-ones, `mismatch` still pulses, and `fail` stays 1.
- Carry-out case: a=b=2^`ADDER_WIDTH`−1 expects `sum` = 2^(`ADDER_WIDTH`+1)−2, with the MSB set.

## Structure
- Shared package `adder_bench_pkg`:
  - default `ADDER_WIDTH` and `LATENCY` constants;
  - the FSM state typedef (IDLE, FILL, CHECK), 2-bit encoded.
- Sub-module `adder_expected_pipe`: parameterised delay line of `LATENCY` stages, each `ADDER_WIDTH+1` bits, with synchronous active-low clear. The top level holds the FSM, comparator and counters.

## Test plan
- Correct adder with random operands: en=1 for 1000 cycles → `mismatch` never 1, `fail`=0, `err_count`=0, `checking`=1 from cycle 2 onward.
- Fault injection: force `sum` bit 0 inverted for one cycle at cycle 50 → `mismatch`=1 in cycle 51 only, `err_count`=1, `fail`=1, `first_err_exp` equals the true sum of the operands from cycle 48.
- Carry extremes: a=b=all-ones → `sum`=0x3FFF…FE (110 bits) accepted. Then a=all-ones, b=1 → `sum`=2^109 accepted.
- Enable gaps: toggle en 1→0→1 with `sum` held at a garbage value while en=0 → no compares in IDLE, and the first two cycles after re-enable produce no mismatch.
- Saturation: `ERR_CNT_WIDTH`=4, constant wrong `sum` for 20 cycles → `err_count` stops at 15, `mismatch` pulses every cycle.
- Reset in CHECK after a failure: rst_n=0 for one edge → `fail`=0, `err_count`=0, state IDLE, and FILL repeats after release.

Source files
------------

// File: rtl/adder_bench_pkg.sv
// Shared constants and FSM state type for the benchmark adder checker.
package adder_bench_pkg;

    localparam int unsigned DEFAULT_ADDER_WIDTH = 109;
    localparam int unsigned DEFAULT_LATENCY     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CHECK = 2'd2
    } check_state_e;

endpackage : adder_bench_pkg

// File: rtl/adder_expected_pipe.sv
// Delay line carrying the recomputed sum so it lines up with the adder output.
module adder_expected_pipe #(
    parameter int unsigned WIDTH   = 110,
    parameter int unsigned LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [LATENCY];
    logic [WIDTH-1:0] stage_d [LATENCY];

    // Next stage contents: new value enters stage 0, others shift by one.
    always_comb begin
        stage_d[0] = din;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Shift every edge out of reset; synchronous clear on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[LATENCY-1];

endmodule : adder_expected_pipe

// File: rtl/adder_result_checker.sv
// Monitor comparing the registered adder output against a delayed reference sum.
module adder_result_checker
    import adder_bench_pkg::*;
#(
    parameter int unsigned ADDER_WIDTH   = DEFAULT_ADDER_WIDTH,
    parameter int unsigned LATENCY       = DEFAULT_LATENCY,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [ADDER_WIDTH-1:0]   a,
    input  logic [ADDER_WIDTH-1:0]   b,
    input  logic [ADDER_WIDTH:0]     sum,
    output logic                     mismatch,
    output logic                     fail,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [ADDER_WIDTH:0]     first_err_exp,
    output logic                     checking
);

    localparam int unsigned SUM_WIDTH = ADDER_WIDTH + 1;
    localparam int unsigned CNT_WIDTH = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_WIDTH-1:0] FILL_LOAD = CNT_WIDTH'(LATENCY - 1);

    logic [SUM_WIDTH-1:0]     exp_in;
    logic [SUM_WIDTH-1:0]     exp_last;

    check_state_e             state_q, state_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic                     mismatch_q, mismatch_d;
    logic                     fail_q, fail_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic [SUM_WIDTH-1:0]     first_err_exp_q, first_err_exp_d;
    logic                     checking_q, checking_d;
    logic                     hit;

    // Full-width reference sum of the current operands, carry kept.
    always_comb begin
        exp_in = {1'b0, a} + {1'b0, b};
    end

    adder_expected_pipe #(
        .WIDTH   (SUM_WIDTH),
        .LATENCY (LATENCY)
    ) u_exp_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (exp_in),
        .dout  (exp_last)
    );

    // FSM next state, compare and error bookkeeping.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        err_count_d     = err_count_q;
        fail_d          = fail_q;
        first_err_exp_d = first_err_exp_q;

        // FILL lasts LATENCY-1 edges so the first compare lands LATENCY edges
        // after en rises; with LATENCY=1 FILL is skipped entirely.
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = FILL_LOAD;
                    state_d = (LATENCY == 1) ? ST_CHECK : ST_FILL;
                end
                ST_FILL: begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                    if (cnt_q <= CNT_WIDTH'(1)) begin
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: state_d = ST_CHECK;
                default:  state_d = ST_IDLE;
            endcase
        end

        // A compare pending on an edge where en has dropped is discarded.
        hit        = (state_q == ST_CHECK) && en && (sum != exp_last);
        mismatch_d = hit;
        if (hit) begin
            if (err_count_q != '1) begin
                err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
            end
            fail_d = 1'b1;
            if (!fail_q) begin
                first_err_exp_d = exp_last;
            end
        end

        checking_d = (state_d == ST_CHECK);
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            mismatch_q      <= 1'b0;
            fail_q          <= 1'b0;
            err_count_q     <= '0;
            first_err_exp_q <= '0;
            checking_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            mismatch_q      <= mismatch_d;
            fail_q          <= fail_d;
            err_count_q     <= err_count_d;
            first_err_exp_q <= first_err_exp_d;
            checking_q      <= checking_d;
        end
    end

    assign mismatch      = mismatch_q;
    assign fail          = fail_q;
    assign err_count     = err_count_q;
    assign first_err_exp = first_err_exp_q;
    assign checking      = checking_q;

endmodule : adder_result_checker

// File: tb/tb_adder_result_checker.sv
// Self-checking bench for adder_result_checker with a cycle-level reference model.
module tb_adder_result_checker;

    localparam int unsigned W  = 109;
    localparam int unsigned L  = 2;
    localparam int unsigned EW = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   sum;
    logic         mismatch;
    logic         fail;
    logic [EW-1:0] err_count;
    logic [W:0]   first_err_exp;
    logic         checking;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [W:0] hist[$];
    int         run;
    logic       m_mismatch;
    logic       m_fail;
    int         m_err;
    logic [W:0] m_first;
    logic       m_checking;
    logic [W:0] fault_exp;

    always #5 clk = ~clk;

    adder_result_checker #(
        .ADDER_WIDTH   (W),
        .LATENCY       (L),
        .ERR_CNT_WIDTH (EW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .a             (a),
        .b             (b),
        .sum           (sum),
        .mismatch      (mismatch),
        .fail          (fail),
        .err_count     (err_count),
        .first_err_exp (first_err_exp),
        .checking      (checking)
    );

    function automatic logic [W-1:0] rand_op();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    function automatic logic [W:0] rand_wide();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[W:0];
    endfunction

    // Sum of the operands sampled 'ago' edges before the most recent edge.
    function automatic logic [W:0] true_sum(int ago);
        return hist[hist.size() - 1 - ago];
    endfunction

    // One clock edge: advance the model, then settle past the edge.
    // A compare happens when en has been high for more than L consecutive
    // edges out of reset; it uses the operands from L edges earlier.
    task automatic tick();
        logic [W:0] expv;
        @(posedge clk);
        hist.push_back({1'b0, a} + {1'b0, b});
        if (hist.size() > 16) void'(hist.pop_front());
        if (!rst_n) begin
            run = 0; m_mismatch = 0; m_fail = 0; m_err = 0;
            m_first = '0; m_checking = 0;
        end else begin
            run = en ? run + 1 : 0;
            expv = true_sum(L);
            m_mismatch = (run > int'(L)) && (sum !== expv);
            if (m_mismatch) begin
                if (m_err < (1 << EW) - 1) m_err++;
                if (!m_fail) begin
                    m_fail  = 1'b1;
                    m_first = expv;
                end
            end
            m_checking = (run >= int'(L));
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = rand_op(); b = rand_op(); sum = rand_wide();
            tick();
        end
        tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL reset_mismatch: got %b expected 0", mismatch); end
        tests++; if (fail !== 1'b0) begin fails++; $display("FAIL reset_fail: got %b expected 0", fail); end
        tests++; if (err_count !== '0) begin fails++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
        tests++; if (first_err_exp !== '0) begin fails++; $display("FAIL reset_first_err_exp: got %h expected 0", first_err_exp); end
        tests++; if (checking !== 1'b0) begin fails++; $display("FAIL reset_checking: got %b expected 0", checking); end
    endtask

    task automatic test_random_correct();
        rst_n = 1'b1; en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = rand_op(); b = rand_op(); sum = true_sum(L - 1);
            tick();
            tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL rand_mismatch[%0d]: got %b expected 0", i, mismatch); end
            tests++; if (checking !== (i >= int'(L) - 1)) begin fails++; $display("FAIL rand_checking[%0d]: got %b expected %b", i, checking, (i >= int'(L) - 1)); end
            tests++; if (checking !== m_checking) begin fails++; $display("FAIL rand_checking_model[%0d]: got %b expected %b", i, checking, m_checking); end
        end
        tests++; if (fail !== 1'b0) begin fails++; $display("FAIL rand_fail: got %b expected 0", fail); end
        tests++; if (err_count !== '0) begin fails++; $display("FAIL rand_err_count: got %0d expected 0", err_count); end
    endtask

    task automatic test_fault_injection();
        logic [W:0] good;
        en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = rand_op(); b = rand_op();
            good = true_sum(L - 1);
            sum = good;
            if (i == 50) begin
                sum[0]    = ~sum[0];
                fault_exp = good;
            end
            tick();
            tests++; if (mismatch !== (i == 50)) begin fails++; $display("FAIL fault_mismatch[%0d]: got %b expected %b", i, mismatch, (i == 50)); end
            tests++; if (mismatch !== m_mismatch) begin fails++; $display("FAIL fault_mismatch_model[%0d]: got %b expected %b", i, mismatch, m_mismatch); end
        end
        tests++; if (err_count !== EW'(1)) begin fails++; $display("FAIL fault_err_count: got %0d expected 1", err_count); end
        tests++; if (fail !== 1'b1) begin fails++; $display("FAIL fault_fail: got %b expected 1", fail); end
        tests++; if (first_err_exp !== fault_exp) begin fails++; $display("FAIL fault_first_err_exp: got %h expected %h", first_err_exp, fault_exp); end
        tests++; if (first_err_exp !== m_first) begin fails++; $display("FAIL fault_first_model: got %h expected %h", first_err_exp, m_first); end
    endtask

    task automatic test_carry();
        logic [W:0] c_ones;
        logic [W:0] c_top;
        c_ones = {{W{1'b1}}, 1'b0};
        c_top  = {1'b1, {W{1'b0}}};
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin a = '1; b = '1; end
            else if (i == 1) begin a = '1; b = W'(1); end
            else begin a = rand_op(); b = rand_op(); end
            if (i == int'(L)) sum = c_ones;
            else if (i == int'(L) + 1) sum = c_top;
            else sum = true_sum(L - 1);
            tick();
            tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL carry_mismatch[%0d]: got %b expected 0", i, mismatch); end
        end
        tests++; if (err_count !== EW'(1)) begin fails++; $display("FAIL carry_err_count: got %0d expected 1", err_count); end
    endtask

    task automatic test_enable_gaps();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = rand_op(); b = rand_op(); sum = rand_wide();
            tick();
            tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL gap_idle_mismatch[%0d]: got %b expected 0", i, mismatch); end
            tests++; if (checking !== 1'b0) begin fails++; $display("FAIL gap_idle_checking[%0d]: got %b expected 0", i, checking); end
        end
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = rand_op(); b = rand_op();
            sum = (i < int'(L)) ? rand_wide() : true_sum(L - 1);
            tick();
            tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL gap_fill_mismatch[%0d]: got %b expected 0", i, mismatch); end
            tests++; if (checking !== (i >= int'(L) - 1)) begin fails++; $display("FAIL gap_checking[%0d]: got %b expected %b", i, checking, (i >= int'(L) - 1)); end
        end
        tests++; if (err_count !== EW'(1)) begin fails++; $display("FAIL gap_err_count: got %0d expected 1", err_count); end
        tests++; if (fail !== 1'b1) begin fails++; $display("FAIL gap_fail: got %b expected 1", fail); end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = rand_op(); b = rand_op();
            sum = true_sum(L - 1) ^ {{W{1'b0}}, 1'b1};
            tick();
            exp_cnt = (i + 2 > 15) ? 15 : i + 2;
            tests++; if (mismatch !== 1'b1) begin fails++; $display("FAIL sat_mismatch[%0d]: got %b expected 1", i, mismatch); end
            tests++; if (err_count !== EW'(exp_cnt)) begin fails++; $display("FAIL sat_err_count[%0d]: got %0d expected %0d", i, err_count, exp_cnt); end
            tests++; if (err_count !== EW'(m_err)) begin fails++; $display("FAIL sat_err_model[%0d]: got %0d expected %0d", i, err_count, m_err); end
        end
        tests++; if (fail !== 1'b1) begin fails++; $display("FAIL sat_fail: got %b expected 1", fail); end
        tests++; if (first_err_exp !== fault_exp) begin fails++; $display("FAIL sat_first_err_exp: got %h expected %h", first_err_exp, fault_exp); end
    endtask

    task automatic test_reset_in_check();
        rst_n = 1'b0; en = 1'b1;
        a = rand_op(); b = rand_op(); sum = rand_wide();
        tick();
        tests++; if (fail !== 1'b0) begin fails++; $display("FAIL rst_fail: got %b expected 0", fail); end
        tests++; if (err_count !== '0) begin fails++; $display("FAIL rst_err_count: got %0d expected 0", err_count); end
        tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL rst_mismatch: got %b expected 0", mismatch); end
        tests++; if (checking !== 1'b0) begin fails++; $display("FAIL rst_checking: got %b expected 0", checking); end
        tests++; if (first_err_exp !== '0) begin fails++; $display("FAIL rst_first_err_exp: got %h expected 0", first_err_exp); end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = rand_op(); b = rand_op();
            sum = (i < int'(L)) ? rand_wide() : true_sum(L - 1);
            tick();
            tests++; if (checking !== (i >= int'(L) - 1)) begin fails++; $display("FAIL rst_refill_checking[%0d]: got %b expected %b", i, checking, (i >= int'(L) - 1)); end
            tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL rst_refill_mismatch[%0d]: got %b expected 0", i, mismatch); end
            tests++; if (fail !== m_fail) begin fails++; $display("FAIL rst_refill_fail[%0d]: got %b expected %b", i, fail, m_fail); end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) hist.push_back('0);
        run = 0; m_mismatch = 0; m_fail = 0; m_err = 0; m_first = '0; m_checking = 0;
        fault_exp = '0;
        rst_n = 1'b0; en = 1'b0; a = '0; b = '0; sum = '0;
        test_reset();
        test_random_correct();
        test_fault_injection();
        test_carry();
        test_enable_gaps();
        test_saturation();
        test_reset_in_check();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_adder_result_checker
